// File: rtl/axi_log_arbiter.sv
// Snoops AXI AR/AW address handshakes, buffers them in per-channel FIFOs and
// issues them one per cycle to a logger using round-robin arbitration.
module axi_log_arbiter #(
    parameter int AXI_ID_BITW   = 8,
    parameter int AXI_ADDR_BITW = 32,
    parameter int AXI_LEN_BITW  = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int DROP_CNT_BITW = 16
) (
    input  logic                     Clk_CI,
    input  logic                     Rst_RI,
    input  logic                     ArValid_SI,
    input  logic                     ArReady_SI,
    input  logic [AXI_ID_BITW-1:0]   ArId_DI,
    input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
    input  logic                     AwValid_SI,
    input  logic                     AwReady_SI,
    input  logic [AXI_ID_BITW-1:0]   AwId_DI,
    input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
    input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
    input  logic                     Enable_SI,
    input  logic                     Clear_SI,
    input  logic                     LogFull_SI,
    output logic                     LogValid_SO,
    output logic                     LogReady_SO,
    output logic [AXI_ID_BITW-1:0]   LogId_DO,
    output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
    output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
    output logic                     LogChan_SO,
    output logic                     LogClear_SO,
    output logic [DROP_CNT_BITW-1:0] DropCntAr_DO,
    output logic [DROP_CNT_BITW-1:0] DropCntAw_DO
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                        state_r, state_nxt_s;
    logic [ENT_W-1:0]              mem_r [2][FIFO_DEPTH];
    logic [1:0][PTR_W-1:0]         rd_ptr_r, wr_ptr_r;
    logic [1:0][CNT_W-1:0]         cnt_r;
    logic [1:0][DROP_CNT_BITW-1:0] drop_cnt_r;
    logic [1:0][ENT_W-1:0]         payload_s;
    logic [1:0]                    evt_s, push_s, pop_s, drop_s, nonempty_s;
    logic                          rr_r, grant_s, issue_s;
    logic [ENT_W-1:0]              head_s;
    logic                          log_valid_r, log_chan_r, log_clear_r;
    logic [ENT_W-1:0]              log_payload_r;

    // Capture, arbitration and push/pop/drop decisions
    always_comb begin
        evt_s[0]     = ArValid_SI && ArReady_SI && Enable_SI && !Clear_SI;
        evt_s[1]     = AwValid_SI && AwReady_SI && Enable_SI && !Clear_SI;
        payload_s[0] = {ArId_DI, ArAddr_DI, ArLen_DI};
        payload_s[1] = {AwId_DI, AwAddr_DI, AwLen_DI};
        for (int c = 0; c < 2; c++) begin
            nonempty_s[c] = (cnt_r[c] != {CNT_W{1'b0}});
        end
        issue_s = (state_r == ST_RUN) && !Clear_SI && (|nonempty_s);
        if (&nonempty_s) begin
            grant_s = rr_r;
        end else if (nonempty_s[0]) begin
            grant_s = 1'b0;
        end else begin
            grant_s = 1'b1;
        end
        head_s = mem_r[grant_s][rd_ptr_r[grant_s]];
        for (int c = 0; c < 2; c++) begin
            pop_s[c]  = issue_s && (grant_s == c[0]);
            // A full FIFO still accepts when its head leaves in the same cycle
            push_s[c] = evt_s[c] && (!cnt_r[c][PTR_W] || pop_s[c]);
            drop_s[c] = evt_s[c] && !push_s[c];
        end
    end

    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge Clk_CI) begin
        for (int c = 0; c < 2; c++) begin
            if (push_s[c]) begin
                mem_r[c][wr_ptr_r[c]] <= payload_s[c];
            end
        end
    end

    // FIFO pointers, occupancy and saturating drop counters
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            cnt_r      <= '0;
            drop_cnt_r <= '0;
        end else if (Clear_SI) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            cnt_r      <= '0;
            drop_cnt_r <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push_s[c]) begin
                    wr_ptr_r[c] <= wr_ptr_r[c] + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                if (pop_s[c]) begin
                    rd_ptr_r[c] <= rd_ptr_r[c] + {{(PTR_W-1){1'b0}}, 1'b1};
                end
                cnt_r[c] <= cnt_r[c] + CNT_W'(push_s[c]) - CNT_W'(pop_s[c]);
                if (drop_s[c] && !(&drop_cnt_r[c])) begin
                    drop_cnt_r[c] <= drop_cnt_r[c] + {{(DROP_CNT_BITW-1){1'b0}}, 1'b1};
                end
            end
        end
    end

    // Control state register
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: Clear wins from every state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (Clear_SI)        state_nxt_s = ST_FLUSH;
                else if (LogFull_SI) state_nxt_s = ST_STALL;
                else                 state_nxt_s = ST_RUN;
            end
            ST_STALL: begin
                if (Clear_SI)        state_nxt_s = ST_FLUSH;
                else if (LogFull_SI) state_nxt_s = ST_STALL;
                else                 state_nxt_s = ST_RUN;
            end
            ST_FLUSH: begin
                if (Clear_SI)        state_nxt_s = ST_FLUSH;
                else                 state_nxt_s = ST_RUN;
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Round-robin pointer (0 = AR next) and registered logger outputs
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            rr_r          <= 1'b0;
            log_valid_r   <= 1'b0;
            log_chan_r    <= 1'b0;
            log_clear_r   <= 1'b0;
            log_payload_r <= '0;
        end else begin
            log_valid_r <= issue_s;
            log_clear_r <= Clear_SI;
            if (Clear_SI) begin
                rr_r <= 1'b0;
            end else if (issue_s) begin
                rr_r <= ~grant_s;
            end
            if (issue_s) begin
                log_chan_r    <= grant_s;
                log_payload_r <= head_s;
            end
        end
    end

    assign LogValid_SO  = log_valid_r;
    assign LogReady_SO  = log_valid_r;
    assign LogChan_SO   = log_chan_r;
    assign LogClear_SO  = log_clear_r;
    assign {LogId_DO, LogAddr_DO, LogLen_DO} = log_payload_r;
    assign DropCntAr_DO = drop_cnt_r[0];
    assign DropCntAw_DO = drop_cnt_r[1];

endmodule

// File: tb/tb_axi_log_arbiter.sv
// Randomised plus directed scoreboard bench for axi_log_arbiter.
module tb_axi_log_arbiter;

    localparam int DEPTH = 4;
    localparam int DMAX  = 15;

    typedef struct packed {
        logic        chan;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ev_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        ar_valid = 1'b0, ar_ready = 1'b0, aw_valid = 1'b0, aw_ready = 1'b0;
    logic [7:0]  ar_id = '0, aw_id = '0, ar_len = '0, aw_len = '0;
    logic [31:0] ar_addr = '0, aw_addr = '0;
    logic        en = 1'b1, clr = 1'b0, full = 1'b0;
    logic        log_valid, log_ready, log_chan, log_clear;
    logic [7:0]  log_id, log_len;
    logic [31:0] log_addr;
    logic [3:0]  drop_ar, drop_aw;

    int n_pass = 0, n_total = 0;

    axi_log_arbiter #(.AXI_ID_BITW(8), .AXI_ADDR_BITW(32), .AXI_LEN_BITW(8),
                      .FIFO_DEPTH(DEPTH), .DROP_CNT_BITW(4)) dut (
        .Clk_CI(clk), .Rst_RI(rst),
        .ArValid_SI(ar_valid), .ArReady_SI(ar_ready), .ArId_DI(ar_id),
        .ArAddr_DI(ar_addr), .ArLen_DI(ar_len),
        .AwValid_SI(aw_valid), .AwReady_SI(aw_ready), .AwId_DI(aw_id),
        .AwAddr_DI(aw_addr), .AwLen_DI(aw_len),
        .Enable_SI(en), .Clear_SI(clr), .LogFull_SI(full),
        .LogValid_SO(log_valid), .LogReady_SO(log_ready),
        .LogId_DO(log_id), .LogAddr_DO(log_addr), .LogLen_DO(log_len),
        .LogChan_SO(log_chan), .LogClear_SO(log_clear),
        .DropCntAr_DO(drop_ar), .DropCntAw_DO(drop_aw)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: queues per channel, mode is 0 run, 1 stall, 2 flush
    ev_t qar[$], qaw[$], expq[$];
    ev_t last_e, e;
    int  mode = 0, dar = 0, daw = 0;
    bit  rr = 1'b0, exp_valid = 1'b0, exp_clear = 1'b0, take_aw;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            qar.delete(); qaw.delete(); expq.delete();
            mode = 0; rr = 1'b0; dar = 0; daw = 0;
            exp_valid = 1'b0; exp_clear = 1'b0; last_e = '0;
        end else begin
            exp_clear = clr;
            exp_valid = 1'b0;
            if (clr) begin
                qar.delete(); qaw.delete();
                dar = 0; daw = 0; rr = 1'b0; mode = 2;
            end else begin
                if (mode == 0 && (qar.size() > 0 || qaw.size() > 0)) begin
                    take_aw = (qar.size() == 0) || (qaw.size() > 0 && rr);
                    e = take_aw ? qaw.pop_front() : qar.pop_front();
                    expq.push_back(e);
                    last_e = e;
                    rr = !take_aw;
                    exp_valid = 1'b1;
                end
                if (ar_valid && ar_ready && en) begin
                    if (qar.size() < DEPTH) qar.push_back({1'b0, ar_id, ar_addr, ar_len});
                    else if (dar < DMAX) dar++;
                end
                if (aw_valid && aw_ready && en) begin
                    if (qaw.size() < DEPTH) qaw.push_back({1'b1, aw_id, aw_addr, aw_len});
                    else if (daw < DMAX) daw++;
                end
                mode = (mode == 2) ? 0 : (full ? 1 : 0);
            end
        end
    end

    // Monitor: compare DUT outputs against the model mid-cycle
    always @(negedge clk) begin
        ev_t got, want;
        got = {log_chan, log_id, log_addr, log_len};
        check("valid", {63'd0, log_valid}, {63'd0, exp_valid});
        check("ready", {63'd0, log_ready}, {63'd0, exp_valid});
        if (exp_valid) begin
            if (expq.size() == 0) begin
                check("scoreboard_empty", 64'd1, 64'd0);
            end else begin
                want = expq.pop_front();
                check("issue_payload", {15'd0, got}, {15'd0, want});
            end
        end else begin
            check("hold_payload", {15'd0, got}, {15'd0, last_e});
        end
        check("log_clear", {63'd0, log_clear}, {63'd0, exp_clear});
        check("drop_ar", {60'd0, drop_ar}, 64'(dar));
        check("drop_aw", {60'd0, drop_aw}, 64'(daw));
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic idle();
        ar_valid = 1'b0; aw_valid = 1'b0; ar_ready = 1'b1; aw_ready = 1'b1;
        en = 1'b1; clr = 1'b0;
    endtask

    task automatic set_ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        ar_valid = 1'b1; ar_ready = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
    endtask

    task automatic set_aw(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len);
        aw_valid = 1'b1; aw_ready = 1'b1; aw_id = id; aw_addr = addr; aw_len = len;
    endtask

    initial begin
        idle();
        cyc(2);
        #1;
        check("rst_outputs", {40'd0, log_valid, log_ready, log_chan, log_clear, drop_ar, drop_aw, log_id, log_len}, 64'd0);
        check("rst_addr", {32'd0, log_addr}, 64'd0);
        rst = 1'b0;
        cyc(1);

        // Single AR event
        set_ar(8'h05, 32'h0000_1000, 8'h03);
        cyc(1);
        idle();
        cyc(1);
        #1;
        check("single_valid", {63'd0, log_valid}, 64'd1);
        check("single_chan", {63'd0, log_chan}, 64'd0);
        check("single_payload", {16'd0, log_id, log_addr, log_len}, {16'd0, 8'h05, 32'h0000_1000, 8'h03});
        cyc(3);

        // Both channels every cycle for six cycles
        for (int i = 0; i < 6; i++) begin
            set_ar(8'(8'h10 + i), 32'h2000 + 32'(i), 8'(i));
            set_aw(8'(8'h20 + i), 32'h3000 + 32'(i), 8'(i));
            cyc(1);
        end
        idle();
        cyc(15);

        // Stall with seven AW events
        full = 1'b1;
        cyc(1);
        for (int i = 0; i < 7; i++) begin
            set_aw(8'(8'h40 + i), 32'h4000 + 32'(i), 8'(i));
            cyc(1);
        end
        idle();
        cyc(2);
        #1;
        check("stall_no_issue", {63'd0, log_valid}, 64'd0);
        check("stall_drops_aw", {60'd0, drop_aw}, 64'd3);
        full = 1'b0;
        cyc(8);

        // Saturate AR drop counter
        full = 1'b1;
        cyc(1);
        for (int i = 0; i < 20; i++) begin
            set_ar(8'(8'h60 + i), 32'h6000 + 32'(i), 8'(i));
            cyc(1);
        end
        idle();
        cyc(1);
        #1;
        check("drop_saturate", {60'd0, drop_ar}, 64'd15);
        full = 1'b0;
        cyc(8);

        // Clear with data held and an event in the clear cycle
        full = 1'b1;
        cyc(1);
        for (int i = 0; i < 2; i++) begin
            set_ar(8'(8'h70 + i), 32'h7000, 8'd1);
            set_aw(8'(8'h78 + i), 32'h7800, 8'd2);
            cyc(1);
        end
        idle();
        clr = 1'b1;
        set_ar(8'hEE, 32'hEEEE_EEEE, 8'hEE);
        cyc(1);
        idle();
        full = 1'b0;
        #1;
        check("flush_drop_ar", {60'd0, drop_ar}, 64'd0);
        check("flush_no_issue", {63'd0, log_valid}, 64'd0);
        cyc(1);
        #1;
        check("clear_pulse_end", {63'd0, log_clear}, 64'd0);
        cyc(6);

        // Asynchronous reset while entries are pending and issuing
        for (int i = 0; i < 3; i++) begin
            set_ar(8'(8'h90 + i), 32'h9000 + 32'(i), 8'(i));
            set_aw(8'(8'h98 + i), 32'h9800 + 32'(i), 8'(i));
            cyc(1);
        end
        idle();
        #1;
        check("pre_rst_valid", {63'd0, log_valid}, 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", {63'd0, log_valid}, 64'd0);
        check("async_rst_payload", {16'd0, log_id, log_addr, log_len}, 64'd0);
        cyc(1);
        rst = 1'b0;
        set_aw(8'hA5, 32'hA000, 8'h07);
        cyc(1);
        idle();
        cyc(4);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            ar_valid = ($urandom_range(0, 99) < 60);
            ar_ready = ($urandom_range(0, 99) < 80);
            aw_valid = ($urandom_range(0, 99) < 60);
            aw_ready = ($urandom_range(0, 99) < 80);
            ar_id = 8'($urandom); ar_addr = $urandom; ar_len = 8'($urandom);
            aw_id = 8'($urandom); aw_addr = $urandom; aw_len = 8'($urandom);
            en   = ($urandom_range(0, 99) < 90);
            clr  = ($urandom_range(0, 99) < 3);
            if (($urandom_range(0, 99) < 10)) full = ~full;
            rst  = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        rst = 1'b0;
        full = 1'b0;
        idle();
        cyc(20);
        check("scoreboard_drained", 64'(expq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
